// File: rtl/ex_stage_if.sv
// Execute-stage boundary signals: ID->EX handoff, EX->ME handoff, data-SRAM
// request, flush/exception controls and the EX bypass/hazard outputs.
// The slave modport is the EX stage's view; master is the surrounding pipeline.
interface ex_stage_if #(
    parameter int ID_BUS_W = 200,
    parameter int EX_BUS_W = 131
);
    logic                ID_to_EX_Valid;
    logic [ID_BUS_W-1:0] ID_to_EX_Bus;
    logic                EX_Allow_in;
    logic                ME_Allow_in;
    logic                EX_to_ME_Valid;
    logic [EX_BUS_W-1:0] EX_to_ME_Bus;
    logic                data_sram_en;
    logic [3:0]          data_sram_we;
    logic [31:0]         data_sram_addr;
    logic [31:0]         data_sram_wdata;
    logic                ME_WB_excp;
    logic                excp_flush;
    logic                ertn_flush;
    logic [4:0]          EX_dest;
    logic [31:0]         EX_Forward_Res;
    logic                EX_is_load;

    modport slave (
        input  ID_to_EX_Valid, ID_to_EX_Bus, ME_Allow_in, ME_WB_excp, excp_flush, ertn_flush,
        output EX_Allow_in, EX_to_ME_Valid, EX_to_ME_Bus, data_sram_en, data_sram_we,
               data_sram_addr, data_sram_wdata, EX_dest, EX_Forward_Res, EX_is_load
    );

    modport master (
        output ID_to_EX_Valid, ID_to_EX_Bus, ME_Allow_in, ME_WB_excp, excp_flush, ertn_flush,
        input  EX_Allow_in, EX_to_ME_Valid, EX_to_ME_Bus, data_sram_en, data_sram_we,
               data_sram_addr, data_sram_wdata, EX_dest, EX_Forward_Res, EX_is_load
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ALU, 32x32 multiply, 34-cycle iterative divide/modulo,
// data-SRAM request generation with misalignment (ALE) detection, and
// the forwarding/load-use outputs consumed by ID.
// mem_size encoding: 0 = byte, 1 = half, 2 = word.
module ex_stage #(
    parameter int          ID_BUS_W = 200,
    parameter int          EX_BUS_W = 131,
    parameter logic [5:0]  ALE_CODE = 6'h09
) (
    input  logic       clk,
    input  logic       reset,
    ex_stage_if.slave  ex_io
);
    typedef struct packed {
        logic        excp_en;
        logic [5:0]  excp_num;
        logic [13:0] csr_num;
        logic        csr_we;
        logic [31:0] csr_wvalue;
        logic        ertn;
        logic [4:0]  alu_op;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] rkd_value;
        logic        mem_en;
        logic        mem_we;
        logic [1:0]  mem_size;
        logic        mem_sign;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] pc;
    } id_bus_t;

    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    id_bus_t     bus_q;
    logic        ex_valid_q;
    div_state_e  div_state_q, div_state_d;
    logic [5:0]  cnt_q;
    logic [31:0] rem_q, quo_q, dvs_q, div_res_q;
    logic        q_neg_q, r_neg_q;

    logic        flush, ready_go, allow_in, is_div, is_signed, is_mod;
    logic [31:0] alu_res, exe_res, result, addr, src1_mag, src2_mag;
    logic [63:0] mul_s, mul_u;
    logic [32:0] trial;
    logic        ge;
    logic        ale, excp_en_out;
    logic [5:0]  excp_num_out;
    logic [4:0]  dest_flag;
    logic [3:0]  we_lanes;
    logic [31:0] wdata_lanes;

    assign flush     = ex_io.excp_flush | ex_io.ertn_flush;
    assign is_div    = bus_q.alu_op inside {5'd16, 5'd17, 5'd18, 5'd19};
    assign is_signed = bus_q.alu_op inside {5'd16, 5'd18};
    assign is_mod    = bus_q.alu_op inside {5'd18, 5'd19};
    assign ready_go  = is_div ? (div_state_q == DIV_DONE) : 1'b1;
    assign allow_in  = !ex_valid_q | (ready_go & ex_io.ME_Allow_in);

    // Stage valid: cleared by reset/flush; a flush also drops an instruction arriving this cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ex_valid_q <= 1'b0;
        end else if (allow_in) begin
            ex_valid_q <= ex_io.ID_to_EX_Valid;
        end
    end

    // Payload register; only meaningful while ex_valid_q is set.
    // NOTE: wide data registers are not reset; the valid bit alone qualifies them.
    always_ff @(posedge clk) begin
        if (ex_io.ID_to_EX_Valid && allow_in) begin
            bus_q <= id_bus_t'(ex_io.ID_to_EX_Bus);
        end
    end

    // ALU and multiplier (single cycle).
    assign mul_s = $signed(bus_q.src1) * $signed(bus_q.src2);
    assign mul_u = bus_q.src1 * bus_q.src2;

    // Combinational ALU result selected by alu_op.
    // NOTE: default assigned first so every path drives alu_res and no latch is inferred.
    always_comb begin
        alu_res = 32'h0;
        case (bus_q.alu_op)
            5'd0:  alu_res = bus_q.src1 + bus_q.src2;
            5'd1:  alu_res = bus_q.src1 - bus_q.src2;
            5'd2:  alu_res = {31'h0, $signed(bus_q.src1) < $signed(bus_q.src2)};
            5'd3:  alu_res = {31'h0, bus_q.src1 < bus_q.src2};
            5'd4:  alu_res = bus_q.src1 & bus_q.src2;
            5'd5:  alu_res = bus_q.src1 | bus_q.src2;
            5'd6:  alu_res = ~(bus_q.src1 | bus_q.src2);
            5'd7:  alu_res = bus_q.src1 ^ bus_q.src2;
            5'd8:  alu_res = bus_q.src1 << bus_q.src2[4:0];
            5'd9:  alu_res = bus_q.src1 >> bus_q.src2[4:0];
            5'd10: alu_res = $signed(bus_q.src1) >>> bus_q.src2[4:0];
            5'd11: alu_res = bus_q.src2;
            5'd12: alu_res = mul_s[31:0];
            5'd13: alu_res = mul_s[63:32];
            5'd14: alu_res = mul_u[63:32];
            default: alu_res = 32'h0;
        endcase
    end

    // Divider: restoring division on magnitudes, sign fix-up in the final BUSY cycle.
    assign src1_mag = (is_signed && bus_q.src1[31]) ? -bus_q.src1 : bus_q.src1;
    assign src2_mag = (is_signed && bus_q.src2[31]) ? -bus_q.src2 : bus_q.src2;
    assign trial    = {rem_q, quo_q[31]};
    assign ge       = trial >= {1'b0, dvs_q};

    // Divider state register; reset and flush abort any divide in flight.
    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            div_state_q <= DIV_IDLE;
        end else begin
            div_state_q <= div_state_d;
        end
    end

    // Divider next-state: start on a valid div op, 32 iterations plus fix-up, hold DONE until ME accepts.
    always_comb begin
        div_state_d = div_state_q;
        case (div_state_q)
            DIV_IDLE: if (ex_valid_q && is_div) div_state_d = DIV_BUSY;
            DIV_BUSY: if (cnt_q == 6'd32) div_state_d = DIV_DONE;
            DIV_DONE: if (ex_io.ME_Allow_in) div_state_d = DIV_IDLE;
            default:  div_state_d = DIV_IDLE;
        endcase
    end

    // Divider datapath: load magnitudes, iterate, then store the sign-corrected result.
    always_ff @(posedge clk) begin
        case (div_state_q)
            DIV_IDLE: begin
                rem_q   <= 32'h0;
                quo_q   <= src1_mag;
                dvs_q   <= src2_mag;
                cnt_q   <= 6'd0;
                q_neg_q <= is_signed & (bus_q.src1[31] ^ bus_q.src2[31]);
                r_neg_q <= is_signed & bus_q.src1[31];
            end
            DIV_BUSY: begin
                if (cnt_q == 6'd32) begin
                    if (is_mod) div_res_q <= r_neg_q ? -rem_q : rem_q;
                    else        div_res_q <= q_neg_q ? -quo_q : quo_q;
                end else begin
                    rem_q <= ge ? (trial[31:0] - dvs_q) : trial[31:0];
                    quo_q <= {quo_q[30:0], ge};
                    cnt_q <= cnt_q + 6'd1;
                end
            end
            default: ;
        endcase
    end

    // Memory request, misalignment and load-extension encoding.
    assign addr         = bus_q.src1 + bus_q.src2;
    assign ale          = bus_q.mem_en & (((bus_q.mem_size == SZ_HALF) & addr[0]) |
                                          ((bus_q.mem_size == SZ_WORD) & (addr[1:0] != 2'b00)));
    assign excp_en_out  = bus_q.excp_en | ale;
    assign excp_num_out = bus_q.excp_en ? bus_q.excp_num : ALE_CODE;

    // Byte strobes and lane-replicated store data by access size.
    always_comb begin
        we_lanes    = 4'b0000;
        wdata_lanes = bus_q.rkd_value;
        case (bus_q.mem_size)
            SZ_BYTE: begin
                we_lanes    = 4'b0001 << addr[1:0];
                wdata_lanes = {4{bus_q.rkd_value[7:0]}};
            end
            SZ_HALF: begin
                we_lanes    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{bus_q.rkd_value[15:0]}};
            end
            default: we_lanes = 4'b1111;
        endcase
    end

    assign dest_flag = (!bus_q.res_from_mem || bus_q.mem_size == SZ_WORD) ? 5'b00000 :
                       {bus_q.mem_sign, bus_q.mem_size == SZ_BYTE, bus_q.mem_size == SZ_HALF, addr[1:0]};

    assign exe_res = is_div ? div_res_q : alu_res;
    assign result  = bus_q.mem_en ? addr : exe_res;

    assign ex_io.EX_Allow_in     = allow_in;
    assign ex_io.EX_to_ME_Valid  = ex_valid_q & ready_go;
    assign ex_io.EX_to_ME_Bus    = {excp_en_out, excp_num_out, bus_q.csr_num, bus_q.csr_we,
                                    bus_q.csr_wvalue, bus_q.ertn, dest_flag, bus_q.pc, result,
                                    bus_q.res_from_mem, bus_q.gr_we, bus_q.dest};
    assign ex_io.data_sram_en    = ex_valid_q & bus_q.mem_en & !excp_en_out & !ex_io.ME_WB_excp &
                                   !flush & ex_io.ME_Allow_in;
    assign ex_io.data_sram_we    = (ex_valid_q && bus_q.mem_en && bus_q.mem_we) ? we_lanes : 4'b0000;
    assign ex_io.data_sram_addr  = addr;
    assign ex_io.data_sram_wdata = wdata_lanes;
    assign ex_io.EX_dest         = (ex_valid_q && bus_q.gr_we) ? bus_q.dest : 5'd0;
    assign ex_io.EX_Forward_Res  = result;
    assign ex_io.EX_is_load      = ex_valid_q & bus_q.res_from_mem;
endmodule
